// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: load-use hazard detection, bubble insertion, stall back-pressure.
// Optional performance counters are built when the ID_EX_PERF_EN macro is defined.
module id_ex_stage #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid,
  input  logic [DWIDTH-1:0] id_pc,
  input  logic [4:0]        id_rs1_id,
  input  logic [4:0]        id_rs2_id,
  input  logic [4:0]        id_rdst_id,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [DWIDTH-1:0] id_rs1,
  input  logic [DWIDTH-1:0] id_rs2,
  input  logic [DWIDTH-1:0] id_imm,
  input  logic [3:0]        id_alu_op,
  input  logic              id_we_regfile,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              ex_flush,
  input  logic              mem_stall,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DWIDTH-1:0] ex_pc,
  output logic [4:0]        ex_rs1_id,
  output logic [4:0]        ex_rs2_id,
  output logic [4:0]        ex_rdst_id,
  output logic [DWIDTH-1:0] ex_rs1,
  output logic [DWIDTH-1:0] ex_rs2,
  output logic [DWIDTH-1:0] ex_imm,
  output logic [3:0]        ex_alu_op,
  output logic              ex_we_regfile,
  output logic              ex_mem_read,
  output logic              ex_mem_write
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       perf_load_use,
  output logic [31:0]       perf_flush
`endif
);

  typedef enum logic [1:0] {
    ACT_LOAD  = 2'd0,
    ACT_HOLD  = 2'd1,
    ACT_FLUSH = 2'd2,
    ACT_LU    = 2'd3
  } act_e;

  logic              ex_valid_r;
  logic [DWIDTH-1:0] ex_pc_r;
  logic [4:0]        ex_rs1_id_r;
  logic [4:0]        ex_rs2_id_r;
  logic [4:0]        ex_rdst_id_r;
  logic [DWIDTH-1:0] ex_rs1_r;
  logic [DWIDTH-1:0] ex_rs2_r;
  logic [DWIDTH-1:0] ex_imm_r;
  logic [3:0]        ex_alu_op_r;
  logic              ex_we_regfile_r;
  logic              ex_mem_read_r;
  logic              ex_mem_write_r;
  logic              lu_s;
  act_e              act_s;

  // Hazard detection and per-edge action selection (hold > flush > load-use > load)
  always_comb begin
    lu_s  = 1'b0;
    act_s = ACT_LOAD;
    lu_s  = ex_valid_r && ex_mem_read_r && (ex_rdst_id_r != 5'd0) && id_valid &&
            ((id_uses_rs1 && (id_rs1_id == ex_rdst_id_r)) ||
             (id_uses_rs2 && (id_rs2_id == ex_rdst_id_r)));
    if (mem_stall) begin
      act_s = ACT_HOLD;
    end else if (ex_flush) begin
      act_s = ACT_FLUSH;
    end else if (lu_s) begin
      act_s = ACT_LU;
    end else begin
      act_s = ACT_LOAD;
    end
  end

  // A flush kills ID upstream, so a coincident load-use hazard must not hold IF/ID
  assign id_stall = mem_stall | (lu_s & ~ex_flush);

  // EX-stage register bank; bubbles clear control and register IDs, data fields keep stale values
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid_r      <= 1'b0;
      ex_pc_r         <= '0;
      ex_rs1_id_r     <= 5'd0;
      ex_rs2_id_r     <= 5'd0;
      ex_rdst_id_r    <= 5'd0;
      ex_rs1_r        <= '0;
      ex_rs2_r        <= '0;
      ex_imm_r        <= '0;
      ex_alu_op_r     <= 4'd0;
      ex_we_regfile_r <= 1'b0;
      ex_mem_read_r   <= 1'b0;
      ex_mem_write_r  <= 1'b0;
    end else begin
      case (act_s)
        ACT_LOAD: begin
          ex_valid_r <= id_valid;
          ex_pc_r    <= id_pc;
          ex_rs1_r   <= id_rs1;
          ex_rs2_r   <= id_rs2;
          ex_imm_r   <= id_imm;
          if (id_valid) begin
            ex_rs1_id_r     <= id_rs1_id;
            ex_rs2_id_r     <= id_rs2_id;
            ex_rdst_id_r    <= id_rdst_id;
            ex_alu_op_r     <= id_alu_op;
            ex_we_regfile_r <= id_we_regfile;
            ex_mem_read_r   <= id_mem_read;
            ex_mem_write_r  <= id_mem_write;
          end else begin
            ex_rs1_id_r     <= 5'd0;
            ex_rs2_id_r     <= 5'd0;
            ex_rdst_id_r    <= 5'd0;
            ex_alu_op_r     <= 4'd0;
            ex_we_regfile_r <= 1'b0;
            ex_mem_read_r   <= 1'b0;
            ex_mem_write_r  <= 1'b0;
          end
        end
        ACT_FLUSH, ACT_LU: begin
          ex_valid_r      <= 1'b0;
          ex_rs1_id_r     <= 5'd0;
          ex_rs2_id_r     <= 5'd0;
          ex_rdst_id_r    <= 5'd0;
          ex_alu_op_r     <= 4'd0;
          ex_we_regfile_r <= 1'b0;
          ex_mem_read_r   <= 1'b0;
          ex_mem_write_r  <= 1'b0;
        end
        ACT_HOLD: begin
          ex_valid_r <= ex_valid_r;
        end
        default: begin
          ex_valid_r <= ex_valid_r;
        end
      endcase
    end
  end

  assign ex_valid      = ex_valid_r;
  assign ex_pc         = ex_pc_r;
  assign ex_rs1_id     = ex_rs1_id_r;
  assign ex_rs2_id     = ex_rs2_id_r;
  assign ex_rdst_id    = ex_rdst_id_r;
  assign ex_rs1        = ex_rs1_r;
  assign ex_rs2        = ex_rs2_r;
  assign ex_imm        = ex_imm_r;
  assign ex_alu_op     = ex_alu_op_r;
  assign ex_we_regfile = ex_we_regfile_r;
  assign ex_mem_read   = ex_mem_read_r;
  assign ex_mem_write  = ex_mem_write_r;

`ifdef ID_EX_PERF_EN
  logic [31:0] perf_load_use_r;
  logic [31:0] perf_flush_r;

  // Bubble counters; a held edge never counts, and both wrap naturally
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_load_use_r <= 32'd0;
      perf_flush_r    <= 32'd0;
    end else begin
      if (act_s == ACT_LU) begin
        perf_load_use_r <= perf_load_use_r + 32'd1;
      end else begin
        perf_load_use_r <= perf_load_use_r;
      end
      if (act_s == ACT_FLUSH) begin
        perf_flush_r <= perf_flush_r + 32'd1;
      end else begin
        perf_flush_r <= perf_flush_r;
      end
    end
  end

  assign perf_load_use = perf_load_use_r;
  assign perf_flush    = perf_flush_r;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/stall/reset steps followed by randomized traffic
// checked against a behavioural model of the EX-stage contents.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_id, id_rs2_id, id_rdst_id;
  logic        id_uses_rs1, id_uses_rs2;
  logic [31:0] id_rs1, id_rs2, id_imm;
  logic [3:0]  id_alu_op;
  logic        id_we_regfile, id_mem_read, id_mem_write;
  logic        ex_flush, mem_stall;
  logic        id_stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1_id, ex_rs2_id, ex_rdst_id;
  logic [31:0] ex_rs1, ex_rs2, ex_imm;
  logic [3:0]  ex_alu_op;
  logic        ex_we_regfile, ex_mem_read, ex_mem_write;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_load_use, perf_flush;
`endif

  id_ex_stage #(.DWIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id), .id_rdst_id(id_rdst_id),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm), .id_alu_op(id_alu_op),
    .id_we_regfile(id_we_regfile), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .ex_flush(ex_flush), .mem_stall(mem_stall), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_id(ex_rs1_id), .ex_rs2_id(ex_rs2_id),
    .ex_rdst_id(ex_rdst_id), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_we_regfile(ex_we_regfile), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write)
`ifdef ID_EX_PERF_EN
    , .perf_load_use(perf_load_use), .perf_flush(perf_flush)
`endif
  );

  always #5 clk = ~clk;

  // Expected EX-stage contents: the instruction currently sitting in EX plus bubble counts
  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1_id, rs2_id, rdst_id;
    logic [31:0] rs1, rs2, imm;
    logic [3:0]  alu_op;
    logic        we, mr, mw;
    logic [31:0] n_lu, n_fl;
  } model_t;

  model_t m;
  int checks = 0;
  int errors = 0;
  logic [31:0] lu0, fl0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m.valid = 1'b0; m.pc = 32'd0; m.rs1_id = 5'd0; m.rs2_id = 5'd0; m.rdst_id = 5'd0;
    m.rs1 = 32'd0; m.rs2 = 32'd0; m.imm = 32'd0; m.alu_op = 4'd0;
    m.we = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.n_lu = 32'd0; m.n_fl = 32'd0;
  endtask

  // ID depends on a load result still in EX
  function automatic logic ref_lu();
    logic dep;
    dep = (id_uses_rs1 && id_rs1_id == m.rdst_id) || (id_uses_rs2 && id_rs2_id == m.rdst_id);
    return m.valid && m.mr && (m.rdst_id != 5'd0) && id_valid && dep;
  endfunction

  task automatic model_edge();
    logic hz;
    hz = ref_lu();
    if (mem_stall) return;
    if (ex_flush || hz) begin
      m.valid = 1'b0; m.rs1_id = 5'd0; m.rs2_id = 5'd0; m.rdst_id = 5'd0;
      m.alu_op = 4'd0; m.we = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
      if (ex_flush) m.n_fl = m.n_fl + 32'd1;
      else          m.n_lu = m.n_lu + 32'd1;
    end else begin
      m.pc = id_pc; m.rs1 = id_rs1; m.rs2 = id_rs2; m.imm = id_imm;
      m.valid   = id_valid;
      m.rs1_id  = id_valid ? id_rs1_id : 5'd0;
      m.rs2_id  = id_valid ? id_rs2_id : 5'd0;
      m.rdst_id = id_valid ? id_rdst_id : 5'd0;
      m.alu_op  = id_valid ? id_alu_op : 4'd0;
      m.we = id_valid & id_we_regfile;
      m.mr = id_valid & id_mem_read;
      m.mw = id_valid & id_mem_write;
    end
  endtask

  task automatic check_ex(input string tag);
    chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, m.valid});
    chk({tag, ".rs1_id"}, {27'd0, ex_rs1_id}, {27'd0, m.rs1_id});
    chk({tag, ".rs2_id"}, {27'd0, ex_rs2_id}, {27'd0, m.rs2_id});
    chk({tag, ".rdst_id"}, {27'd0, ex_rdst_id}, {27'd0, m.rdst_id});
    chk({tag, ".alu_op"}, {28'd0, ex_alu_op}, {28'd0, m.alu_op});
    chk({tag, ".ctrl"}, {29'd0, ex_we_regfile, ex_mem_read, ex_mem_write}, {29'd0, m.we, m.mr, m.mw});
    if (m.valid) begin
      chk({tag, ".pc"}, ex_pc, m.pc);
      chk({tag, ".rs1"}, ex_rs1, m.rs1);
      chk({tag, ".rs2"}, ex_rs2, m.rs2);
      chk({tag, ".imm"}, ex_imm, m.imm);
    end
`ifdef ID_EX_PERF_EN
    chk({tag, ".perf_lu"}, perf_load_use, m.n_lu);
    chk({tag, ".perf_fl"}, perf_flush, m.n_fl);
`endif
  endtask

  // Inputs are set at the falling edge; check stall, take one rising edge, then check EX
  task automatic step(input string tag);
    #1;
    chk({tag, ".id_stall"}, {31'd0, id_stall}, {31'd0, mem_stall | (ref_lu() & ~ex_flush)});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_ex(tag);
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic mr);
    id_valid = v; id_rs1_id = r1; id_rs2_id = r2; id_rdst_id = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_mem_read = mr;
    id_pc = $urandom; id_rs1 = $urandom; id_rs2 = $urandom; id_imm = $urandom;
    id_alu_op = 4'($urandom_range(0, 15)); id_we_regfile = 1'b1; id_mem_write = 1'b0;
  endtask

  initial begin
    rstn = 1'b1; ex_flush = 1'b0; mem_stall = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    model_reset();
    #1 check_ex("reset");
    chk("reset.id_stall", {31'd0, id_stall}, 32'd0);
    @(negedge clk) rstn = 1'b1;

    // lw x5, then add x6,x5,x7
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1);
    step("lw5");
    chk("lw5.rdst_const", {27'd0, ex_rdst_id}, 32'd5);
    drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0);
    #1 chk("lu.stall_const", {31'd0, id_stall}, 32'd1);
    step("lu_bubble");
    chk("lu_bubble.valid_const", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble.rs1_const", {27'd0, ex_rs1_id}, 32'd0);
    step("lu_load");
    chk("lu_load.rs1_const", {27'd0, ex_rs1_id}, 32'd5);
    chk("lu_load.valid_const", {31'd0, ex_valid}, 32'd1);

    // lw x0 followed by reader of x0
    drive(1'b1, 5'd3, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1);
    step("lw0");
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0);
    #1 chk("x0.stall_const", {31'd0, id_stall}, 32'd0);
    step("x0_reader");

    // lw x5 then addi x6,x8,1 with unused rs2 field = 5
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1);
    step("lw5b");
    drive(1'b1, 5'd8, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    #1 chk("nors2.stall_const", {31'd0, id_stall}, 32'd0);
    step("addi");

    // flush coincident with load-use
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1);
    step("lw5c");
    drive(1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0);
    ex_flush = 1'b1;
    lu0 = m.n_lu; fl0 = m.n_fl;
    #1 chk("flush.stall_const", {31'd0, id_stall}, 32'd0);
    step("flush_lu");
    chk("flush_lu.valid_const", {31'd0, ex_valid}, 32'd0);
`ifdef ID_EX_PERF_EN
    chk("flush_lu.perf_fl_delta", perf_flush, fl0 + 32'd1);
    chk("flush_lu.perf_lu_delta", perf_load_use, lu0);
`endif
    ex_flush = 1'b0;

    // mem_stall for 3 cycles while a load-use hazard is pending
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1);
    step("lw5d");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'b1, 1'b1, 1'($urandom_range(0, 1)));
      mem_stall = 1'b1;
      #1 chk("mstall.stall_const", {31'd0, id_stall}, 32'd1);
      step("mstall");
      chk("mstall.rdst_const", {27'd0, ex_rdst_id}, 32'd5);
    end
    mem_stall = 1'b0;
    drive(1'b1, 5'd5, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0);
    step("mstall_bubble");
    step("mstall_load");

`ifdef ID_EX_PERF_EN
    // counter wrap
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1);
    step("lw5e");
    force dut.perf_load_use_r = 32'hFFFF_FFFF;
    #1 release dut.perf_load_use_r;
    m.n_lu = 32'hFFFF_FFFF;
    drive(1'b1, 5'd5, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0);
    step("wrap");
    chk("wrap.perf_lu_const", perf_load_use, 32'd0);
`endif

    // asynchronous reset mid-operation
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1);
    step("lw5f");
    #2 rstn = 1'b0;
    model_reset();
    #1 check_ex("async_rst");
    chk("async_rst.rdst_const", {27'd0, ex_rdst_id}, 32'd0);
    chk("async_rst.stall_const", {31'd0, id_stall}, 32'd0);
    @(negedge clk) rstn = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
    id_pc = 32'h0000_0100;
    step("post_rst");
    chk("post_rst.pc_const", ex_pc, 32'h0000_0100);
    chk("post_rst.valid_const", {31'd0, ex_valid}, 32'd1);

    // randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) < 4));
      id_mem_write = 1'($urandom_range(0, 1));
      id_we_regfile = 1'($urandom_range(0, 1));
      ex_flush = ($urandom_range(0, 9) == 0);
      mem_stall = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
